i2s_audio_tx: RTL and testbench
===============================

# i2s_audio_tx

Parametrised I2S audio transmitter for the Pocket audio output (`audio_mclk`, `audio_lrck`, `audio_dac`). It replaces the fixed silence generator with a block that serialises real stereo PCM samples. Samples are accepted from core logic through a valid/ready FIFO. MCLK is synthesised by a fractional accumulator, and all bit timing is derived as clock enables inside a single clock domain, with no derived clocks.

## Interface
- `ACC_INC`, default 245760: accumulator increment per clock (2 × MCLK scaled).
- `ACC_MOD`, default 742500: accumulator modulus (clock scaled by the same factor).
- `ACC_WIDTH`, default 22: accumulator width. Must hold `ACC_MOD + ACC_INC - 1`.
- `MCLK_DIV`, default 4: MCLK rising edges per SCLK period. Even, ≥2.
- `SLOT_BITS`, default 32: SCLK periods per channel slot.
- `SAMPLE_WIDTH`, default 16: PCM bits per channel, 1..`SLOT_BITS`.
- `FIFO_DEPTH`, default 4: stereo entries, power of 2, ≥2.
- `UNDERRUN_MODE`, default 0: 0 = emit zeros on underrun, 1 = repeat the last frame.

Ports:
- `clock` in 1: single clock (clk_74a in the top level).
- `reset` in 1: synchronous, active-high.
- `sample_l` in `SAMPLE_WIDTH`: left PCM, two's complement.
- `sample_r` in `SAMPLE_WIDTH`: right PCM.
- `sample_valid` in 1: producer has a pair.
- `sample_ready` out 1: FIFO not full.
- `fifo_level` out clog2(`FIFO_DEPTH`)+1: entries held.
- `frame_strobe` out 1: one-cycle pulse at each frame start.
- `underrun` out 1: one-cycle pulse when a frame starts with the FIFO empty.
- `audio_mclk` out 1: master clock.
- `audio_lrck` out 1: word select; 0 = left.
- `audio_dac` out 1: serial data.

## Operation
- **MCLK accumulator**, every cycle:
  - If `acc ≥ ACC_MOD`: `acc ← acc − ACC_MOD + ACC_INC` and `audio_mclk` toggles.
  - Else: `acc ← acc + ACC_INC`.
  - A cycle in which `audio_mclk` goes 0→1 is an *mclk_rise*.
- **SCLK divider**: `div_cnt` counts mclk_rise events modulo `MCLK_DIV`. When a rise takes `div_cnt` from `MCLK_DIV−1` to 0, that cycle is a *bit_tick* (SCLK falling edge).
- **Bit position**: `pos` counts bit_tick events modulo 2·`SLOT_BITS`.
  - `audio_lrck ← (new pos ≥ SLOT_BITS)`.
- **`audio_dac` at new pos p** (S = `SLOT_BITS`, W = `SAMPLE_WIDTH`):
  - p in 1..W: left bit W−p.
  - p in S+1..S+W: right bit W−(p−S).
  - p = 0 with W = S: previous frame's right LSB.
  - All other positions: 0.
- **Frame start** (bit_tick with new pos = 0):
  - Pulse `frame_strobe`.
  - FIFO non-empty: pop into the frame latch.
  - FIFO empty: pulse `underrun`; the latch becomes zero (mode 0) or is held (mode 1).
  - The right-LSB carry for p = 0 uses the old latch value.
- **FIFO**:
  - Push when `sample_valid && sample_ready`.
  - `sample_ready = ~reset && fifo_level < FIFO_DEPTH`, combinational from the registered level.
  - Push and pop in the same cycle: level unchanged.
  - Push while full: impossible, because ready is low.
  - Push into an empty FIFO on a frame-start cycle: no bypass. The pop sees empty, so underrun is flagged and the pushed entry serves the next frame.
- **Reset**:
  - `acc`, `div_cnt` = 0; `pos` = 2S−1, so the first bit_tick starts a frame.
  - FIFO empty, frame latch = 0.
  - All outputs 0, including `sample_ready` while `reset` is high.
  - Reset mid-frame aborts the frame immediately.

## Timing
- MCLK toggle rate = f_clk·`ACC_INC`/`ACC_MOD`. Defaults: 74.25 MHz gives 12.288 MHz MCLK, with ±1 clock edge jitter.
- Frame rate = f_MCLK / (`MCLK_DIV`·2·S). Defaults: 48 kHz.
- `audio_mclk`, `audio_lrck`, `audio_dac`, `frame_strobe` and `underrun` are registered and change on the same clock edge as the bit_tick mclk_rise.
- `fifo_level` updates one cycle after a push or pop. `sample_ready` falls in the cycle after the push that fills the FIFO.
- Latency: a pair pushed into an empty FIFO at least one cycle before frame start has its left MSB on `audio_dac` one bit_tick after frame start, i.e. `MCLK_DIV` mclk_rise events later.

## Test plan
- **Reset**: hold `reset` 5 cycles → all outputs 0 and `fifo_level` = 0. First cycle after release → `sample_ready` = 1.
- **MCLK rate**, defaults: count `audio_mclk` toggles over 742500 clocks after reset → exactly 245760. Frame_strobe spacing = 256 mclk_rise events.
- **Serialisation**: push L=16'hA5A5, R=16'h5A5A.
  - Next frame: `audio_lrck` low for 32 bit_ticks; `dac` = 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 at p=1..16, then zeros.
  - Right slot mirrors with 5A5A.
  - Repeat with `SAMPLE_WIDTH`=`SLOT_BITS`=32 → the p=0 carry equals the prior right LSB.
- **Underrun**: no pushes → `underrun` pulses with every `frame_strobe` and `dac` is constantly 0 (mode 0). In mode 1, after one frame of 0x1234/0x8001, the same bits repeat every frame.
- **FIFO full**: 6 back-to-back valid pushes with depth 4 → 4 accepted, `sample_ready` low, `fifo_level` = 4. After the next frame start, level = 3 and ready = 1. Popped order matches push order.
- **Reset mid-frame**: assert `reset` at p=10 with 2 entries queued → FIFO empty, `audio_lrck`/`audio_dac` 0. After release, the first frame shows `underrun`.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S stereo transmitter with fractional MCLK, sample FIFO and clock-enable bit timing
module i2s_audio_tx #(
    parameter int ACC_INC       = 245760,
    parameter int ACC_MOD       = 742500,
    parameter int ACC_WIDTH     = 22,
    parameter int MCLK_DIV      = 4,
    parameter int SLOT_BITS     = 32,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int UNDERRUN_MODE = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [SAMPLE_WIDTH-1:0]       sample_l,
    input  logic [SAMPLE_WIDTH-1:0]       sample_r,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_strobe,
    output logic                          underrun,
    output logic                          audio_mclk,
    output logic                          audio_lrck,
    output logic                          audio_dac
);
    localparam int PW = $clog2(2 * SLOT_BITS);
    localparam int DW = $clog2(MCLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [ACC_WIDTH-1:0] MOD      = ACC_WIDTH'(ACC_MOD);
    localparam logic [ACC_WIDTH-1:0] INC      = ACC_WIDTH'(ACC_INC);
    localparam logic [DW-1:0]        DIV_LAST = DW'(MCLK_DIV - 1);
    localparam logic [PW-1:0]        POS_LAST = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0]        POS_SLOT = PW'(SLOT_BITS);
    localparam logic [LW-1:0]        DEPTH_L  = LW'(FIFO_DEPTH);

    logic [ACC_WIDTH-1:0]    acc;
    logic [DW-1:0]           div_cnt;
    logic [PW-1:0]           pos;
    logic [PW-1:0]           pos_next;
    logic                    mclk_toggle;
    logic                    mclk_rise;
    logic                    bit_tick;
    logic                    frame_start;

    logic [SAMPLE_WIDTH-1:0] lat_l;
    logic [SAMPLE_WIDTH-1:0] lat_r;
    logic [SAMPLE_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;

    int                      dac_pos;
    logic [SAMPLE_WIDTH-1:0] dac_shift;
    logic                    dac_next;

    assign mclk_toggle  = (acc >= MOD);
    assign mclk_rise    = mclk_toggle && !audio_mclk;
    assign bit_tick     = mclk_rise && (div_cnt == DIV_LAST);
    assign pos_next     = (pos == POS_LAST) ? '0 : pos + 1'b1;
    assign frame_start  = bit_tick && (pos == POS_LAST);

    assign fifo_empty   = (fifo_level == '0);
    assign sample_ready = !reset && (fifo_level != DEPTH_L);
    assign push         = sample_valid && sample_ready;
    assign pop          = frame_start && !fifo_empty;

    // On a frame start the latch is reloaded on the same edge, so p = 0 still sees the old right LSB.
    always_comb begin
        dac_pos   = int'(pos_next);
        dac_shift = '0;
        dac_next  = 1'b0;
        if (dac_pos >= 1 && dac_pos <= SAMPLE_WIDTH) begin
            dac_shift = lat_l >> (SAMPLE_WIDTH - dac_pos);
            dac_next  = dac_shift[0];
        end else if (dac_pos >= SLOT_BITS + 1 && dac_pos <= SLOT_BITS + SAMPLE_WIDTH) begin
            dac_shift = lat_r >> (SAMPLE_WIDTH - (dac_pos - SLOT_BITS));
            dac_next  = dac_shift[0];
        end else if (dac_pos == 0 && SAMPLE_WIDTH == SLOT_BITS) begin
            dac_next  = lat_r[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc          <= '0;
            audio_mclk   <= 1'b0;
            div_cnt      <= '0;
            pos          <= POS_LAST;
            audio_lrck   <= 1'b0;
            audio_dac    <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
            lat_l        <= '0;
            lat_r        <= '0;
        end else begin
            frame_strobe <= frame_start;
            underrun     <= frame_start && fifo_empty;

            if (mclk_toggle) begin
                acc        <= acc - MOD + INC;
                audio_mclk <= !audio_mclk;
            end else begin
                acc        <= acc + INC;
            end

            if (mclk_rise) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end

            if (bit_tick) begin
                pos        <= pos_next;
                audio_lrck <= (pos_next >= POS_SLOT);
                audio_dac  <= dac_next;
            end

            if (pop) begin
                lat_l <= mem_l[rd_ptr];
                lat_r <= mem_r[rd_ptr];
            end else if (frame_start && UNDERRUN_MODE == 0) begin
                lat_l <= '0;
                lat_r <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_l[wr_ptr] <= sample_l;
            mem_r[wr_ptr] <= sample_r;
        end
    end

    // No bypass: a push landing on a frame-start cycle into an empty FIFO waits for the next frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed bench for i2s_audio_tx, two parameterisations on one clock
module tb_i2s_audio_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, v0, rdy0, strobe0, ur0, mclk0, lrck0, dac0;
    logic [15:0] l0, r0;
    logic [2:0]  lvl0;
    logic        rst1, v1, rdy1, strobe1, ur1, mclk1, lrck1, dac1;
    logic [7:0]  l1, r1;
    logic [1:0]  lvl1;

    i2s_audio_tx #(
        .ACC_INC(3), .ACC_MOD(7), .ACC_WIDTH(4), .MCLK_DIV(2), .SLOT_BITS(32),
        .SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .UNDERRUN_MODE(0)
    ) u0 (
        .clock(clk), .reset(rst0), .sample_l(l0), .sample_r(r0), .sample_valid(v0),
        .sample_ready(rdy0), .fifo_level(lvl0), .frame_strobe(strobe0), .underrun(ur0),
        .audio_mclk(mclk0), .audio_lrck(lrck0), .audio_dac(dac0)
    );

    i2s_audio_tx #(
        .ACC_INC(1), .ACC_MOD(1), .ACC_WIDTH(2), .MCLK_DIV(2), .SLOT_BITS(8),
        .SAMPLE_WIDTH(8), .FIFO_DEPTH(2), .UNDERRUN_MODE(1)
    ) u1 (
        .clock(clk), .reset(rst1), .sample_l(l1), .sample_r(r1), .sample_valid(v1),
        .sample_ready(rdy1), .fifo_level(lvl1), .frame_strobe(strobe1), .underrun(ur1),
        .audio_mclk(mclk1), .audio_lrck(lrck1), .audio_dac(dac1)
    );

    logic sel;
    logic m_mclk, m_strobe, m_underrun, m_dac, m_lrck;
    assign m_mclk     = sel ? mclk1   : mclk0;
    assign m_strobe   = sel ? strobe1 : strobe0;
    assign m_underrun = sel ? ur1     : ur0;
    assign m_dac      = sel ? dac1    : dac0;
    assign m_lrck     = sel ? lrck1   : lrck0;

    int total = 0;
    int bad   = 0;

    logic [63:0] cap_dac, cap_lrck;
    logic        cap_ur, cap_rdy;
    logic [2:0]  cap_lvl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for the next frame_strobe, then records dac/lrck at positions 0..npos-1 (p = 0 ends up as MSB).
    task automatic capture(input int npos);
        int   guard;
        int   rises;
        logic prev;
        cap_dac  = '0;
        cap_lrck = '0;
        guard    = 0;
        @(negedge clk);
        while (!m_strobe && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("strobe_seen", m_strobe, 1);
        if (!m_strobe) return;
        cap_ur   = m_underrun;
        cap_lvl  = lvl0;
        cap_rdy  = rdy0;
        cap_dac  = {cap_dac[62:0], m_dac};
        cap_lrck = {cap_lrck[62:0], m_lrck};
        prev     = m_mclk;
        for (int p = 1; p < npos; p++) begin
            rises = 0;
            while (rises < 2 && guard < 5000) begin
                @(negedge clk);
                guard++;
                if (m_mclk && !prev) rises++;
                prev = m_mclk;
            end
            cap_dac  = {cap_dac[62:0], m_dac};
            cap_lrck = {cap_lrck[62:0], m_lrck};
        end
        check("tick_budget", guard < 5000, 1);
    endtask

    initial begin
        int   toggles, rises, strobes, urs, ones, s_first, s_second;
        logic prev;
        logic [15:0] lv, rv;

        sel = 1'b0;
        rst0 = 1'b1; v0 = 1'b0; l0 = '0; r0 = '0;
        rst1 = 1'b1; v1 = 1'b0; l1 = '0; r1 = '0;

        repeat (5) @(negedge clk);
        check("rst_mclk",   mclk0,   0);
        check("rst_lrck",   lrck0,   0);
        check("rst_dac",    dac0,    0);
        check("rst_strobe", strobe0, 0);
        check("rst_under",  ur0,     0);
        check("rst_ready",  rdy0,    0);
        check("rst_level",  lvl0,    0);
        rst0 = 1'b0;
        #1;
        check("ready_after_rst", rdy0, 1);

        // 701 samples cover accumulator cycles 0..700; acc returns to ACC_MOD at cycle 700 and toggles there.
        prev = mclk0; toggles = 0; rises = 0; strobes = 0; urs = 0; ones = 0; s_first = -1; s_second = -1;
        for (int n = 1; n <= 701; n++) begin
            @(negedge clk);
            if (mclk0 != prev) toggles++;
            if (mclk0 && !prev) rises++;
            prev = mclk0;
            if (strobe0) begin
                strobes++;
                if (s_first < 0) s_first = rises;
                else if (s_second < 0) s_second = rises;
            end
            if (ur0) urs++;
            if (dac0) ones++;
        end
        check("mclk_toggles",   toggles, 300);
        check("strobe_count",   strobes, 2);
        check("underrun_count", urs,     2);
        check("idle_dac_ones",  ones,    0);
        check("first_frame_rise", s_first, 2);
        check("frame_spacing",  s_second - s_first, 128);

        rst0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b0; v0 = 1'b1; l0 = 16'hA5A5; r0 = 16'h5A5A;
        @(negedge clk);
        v0 = 1'b0;
        capture(64);
        check("ser_underrun", cap_ur,   0);
        check("ser_dac",      cap_dac,  64'h52D28000_2D2D0000);
        check("ser_lrck",     cap_lrck, 64'h00000000_FFFFFFFF);

        capture(1);
        check("empty_underrun", cap_ur, 1);
        for (int i = 0; i < 6; i++) begin
            v0 = 1'b1;
            l0 = 16'(16'h1111 * (i + 1));
            r0 = ~l0;
            @(negedge clk);
        end
        v0 = 1'b0;
        check("full_level", lvl0, 4);
        check("full_ready", rdy0, 0);
        for (int k = 0; k < 4; k++) begin
            capture(64);
            lv = 16'(16'h1111 * (k + 1));
            rv = ~lv;
            if (k == 0) begin
                check("pop_level", cap_lvl, 3);
                check("pop_ready", cap_rdy, 1);
            end
            check("fifo_underrun", cap_ur, 0);
            check("fifo_left",  cap_dac[63:32], {1'b0, lv, 15'b0});
            check("fifo_right", cap_dac[31:0],  {1'b0, rv, 15'b0});
        end
        capture(1);
        check("drain_underrun", cap_ur, 1);

        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; l0 = 16'hFFFF; r0 = 16'hFFFF;
            @(negedge clk);
        end
        v0 = 1'b0;
        capture(11);
        check("mid_level_before", lvl0, 2);
        check("mid_dac_before",   dac0, 1);
        rst0 = 1'b1;
        @(negedge clk);
        check("mid_level_after", lvl0,  0);
        check("mid_lrck_after",  lrck0, 0);
        check("mid_dac_after",   dac0,  0);
        check("mid_mclk_after",  mclk0, 0);
        check("mid_ready_after", rdy0,  0);
        rst0 = 1'b0;
        capture(1);
        check("post_rst_underrun", cap_ur,  1);
        check("post_rst_level",    cap_lvl, 0);

        sel = 1'b1;
        rst1 = 1'b0; v1 = 1'b1; l1 = 8'hB4; r1 = 8'h81;
        @(negedge clk);
        v1 = 1'b0;
        capture(16);
        check("w32_a_under", cap_ur, 0);
        check("w32_a_dac",   cap_dac[15:0],  16'h5A40);
        check("w32_a_lrck",  cap_lrck[15:0], 16'h00FF);
        capture(16);
        check("w32_b_under", cap_ur, 1);
        check("w32_b_dac",   cap_dac[15:0], 16'hDA40);
        capture(16);
        check("w32_c_under", cap_ur, 1);
        check("w32_c_dac",   cap_dac[15:0], 16'hDA40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
